// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light controller and its lamp driver:
// state codes, lamp patterns, fault causes and transition rules.
package tl_pkg;

  localparam logic [2:0] START = 3'b111;
  localparam logic [2:0] NS    = 3'b011;
  localparam logic [2:0] NY    = 3'b010;
  localparam logic [2:0] EW    = 3'b000;
  localparam logic [2:0] EY    = 3'b001;

  // Lamp triplets are {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_UNDEF   = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;
  localparam logic [1:0] FC_SHORT   = 2'b11;

  typedef enum logic {
    MODE_RUN   = 1'b0,
    MODE_FAULT = 1'b1
  } mode_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamps_t;

  function automatic logic is_defined(input logic [2:0] code);
    return (code == START) || (code == NS) || (code == NY) ||
           (code == EW) || (code == EY);
  endfunction

  function automatic logic is_green(input logic [2:0] code);
    return (code == NS) || (code == EW);
  endfunction

  function automatic logic is_legal(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    ok = 1'b0;
    if (cur == prev) begin
      ok = 1'b1;
    end else if (cur == START) begin
      ok = is_defined(prev);
    end else begin
      case (prev)
        START:   ok = (cur == NS);
        NS:      ok = (cur == NY);
        NY:      ok = (cur == EW);
        EW:      ok = (cur == EY);
        EY:      ok = (cur == NS);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Any code outside the map falls back to all-red so no head ever shows
  // a proceed aspect on an unrecognised state.
  function automatic lamps_t run_lamps(input logic [2:0] code);
    lamps_t l;
    l.ns = LAMP_RED;
    l.ew = LAMP_RED;
    case (code)
      NS:      l.ns = LAMP_GRN;
      NY:      l.ns = LAMP_YEL;
      EW:      l.ew = LAMP_GRN;
      EY:      l.ew = LAMP_YEL;
      default: begin
        l.ns = LAMP_RED;
        l.ew = LAMP_RED;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_blink.sv
// Flash prescaler for fault mode: counts 0..BLINK_DIV-1 and toggles the
// phase on each wrap. Preset restarts a flash cycle with the lamps lit.
module tl_blink #(
  parameter int                 T_WIDTH   = 8,
  parameter logic [T_WIDTH-1:0] BLINK_DIV = T_WIDTH'(4)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic preset,
  output logic phase_next
);

  localparam logic [T_WIDTH-1:0] ONE      = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] CNT_LAST = BLINK_DIV - ONE;

  logic [T_WIDTH-1:0] cnt;
  logic [T_WIDTH-1:0] cnt_next;
  logic               phase;

  always_comb begin
    cnt_next   = cnt;
    phase_next = phase;
    if (preset) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (en) begin
      if (cnt >= CNT_LAST) begin
        cnt_next   = '0;
        phase_next = ~phase;
      end else begin
        cnt_next = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/tl_lamp_drv.sv
// Lamp driver and independent safety monitor for the traffic-light
// controller. Violations latch a fault that flashes both heads red.
module tl_lamp_drv
  import tl_pkg::*;
#(
  parameter int                 T_WIDTH   = 8,
  parameter logic [T_WIDTH-1:0] MIN_GREEN = T_WIDTH'(4),
  parameter logic [T_WIDTH-1:0] BLINK_DIV = T_WIDTH'(4)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_state,
  input  logic       i_clr_fault,
  output logic [2:0] o_ns_lamp,
  output logic [2:0] o_ew_lamp,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);

  localparam logic [T_WIDTH-1:0] ONE       = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] DWELL_MAX = {T_WIDTH{1'b1}};

  mode_t              mode;
  mode_t              mode_next;
  logic [2:0]         prev_state;
  logic [T_WIDTH-1:0] dwell;
  logic [T_WIDTH-1:0] dwell_next;
  logic               changed;
  logic [1:0]         cause;
  logic [1:0]         code_next;
  logic               blink_en;
  logic               blink_preset;
  logic               blink_phase_next;
  lamps_t             lamps_next;

  tl_blink #(
    .T_WIDTH   (T_WIDTH),
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk        (i_clk),
    .rst        (i_rst),
    .en         (blink_en),
    .preset     (blink_preset),
    .phase_next (blink_phase_next)
  );

  // Dwell counts the cycles the current code has been held, including
  // this one, so a green held N cycles reads N on the cycle it is left.
  always_comb begin
    changed = (i_state != prev_state);
    if (changed) begin
      dwell_next = ONE;
    end else if (dwell == DWELL_MAX) begin
      dwell_next = dwell;
    end else begin
      dwell_next = dwell + ONE;
    end
  end

  always_comb begin
    cause = FC_NONE;
    if (!is_defined(i_state)) begin
      cause = FC_UNDEF;
    end else if (!is_legal(prev_state, i_state)) begin
      cause = FC_ILLEGAL;
    end else if (is_green(prev_state) && changed && (i_state != START) &&
                 (dwell < MIN_GREEN)) begin
      cause = FC_SHORT;
    end
  end

  always_comb begin
    mode_next    = mode;
    code_next    = o_fault_code;
    blink_en     = 1'b0;
    blink_preset = 1'b0;
    case (mode)
      MODE_RUN: begin
        if (cause != FC_NONE) begin
          mode_next    = MODE_FAULT;
          code_next    = cause;
          blink_preset = 1'b1;
        end
      end
      MODE_FAULT: begin
        if (i_clr_fault && (i_state == START)) begin
          mode_next = MODE_RUN;
          code_next = FC_NONE;
        end else begin
          blink_en = 1'b1;
        end
      end
      default: begin
        mode_next = MODE_FAULT;
        code_next = o_fault_code;
      end
    endcase
  end

  always_comb begin
    lamps_next = run_lamps(i_state);
    if (mode_next == MODE_FAULT) begin
      lamps_next.ns = {blink_phase_next, 2'b00};
      lamps_next.ew = {blink_phase_next, 2'b00};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_state   <= START;
      mode         <= MODE_RUN;
      dwell        <= '0;
      o_ns_lamp    <= LAMP_RED;
      o_ew_lamp    <= LAMP_RED;
      o_fault      <= 1'b0;
      o_fault_code <= FC_NONE;
    end else begin
      prev_state   <= i_state;
      mode         <= mode_next;
      dwell        <= dwell_next;
      o_ns_lamp    <= lamps_next.ns;
      o_ew_lamp    <= lamps_next.ew;
      o_fault      <= (mode_next == MODE_FAULT);
      o_fault_code <= code_next;
    end
  end

endmodule
